trigger_capture_buf: RTL and testbench

//  Parametrised successor to the single-sample trigger capture: circular capture buffer that records din every cycle once

---
 rtl/trigcap_pkg.sv | 33 +++
 rtl/trigcap_if.sv | 50 +++++
 rtl/trigcap_ram.sv | 36 +++
 rtl/trigger_capture_buf.sv | 196 +++++++++++++++++++
 tb/tb_trigger_capture_buf.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/trigcap_pkg.sv
// Shared types for the trigger capture buffer: FSM state encoding, trigger
// qualification modes and the mode-qualified trigger helper.
package trigcap_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        WAIT,
        POST,
        DONE
    } state_t;

    localparam logic [1:0] TM_LEVEL = 2'b00;
    localparam logic [1:0] TM_RISE  = 2'b01;
    localparam logic [1:0] TM_FALL  = 2'b10;
    localparam logic [1:0] TM_ANY   = 2'b11;

    // Level mode looks at the raw input so a trigger that is already high
    // when waiting starts fires at once; the edge modes compare against the
    // previous cycle's value.
    function automatic logic mode_match(input logic [1:0] mode,
                                        input logic       cur,
                                        input logic       prev);
        case (mode)
            TM_LEVEL: return cur;
            TM_RISE:  return cur & ~prev;
            TM_FALL:  return ~cur & prev;
            TM_ANY:   return cur ^ prev;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/trigcap_if.sv
// Bus bundle between the sampled data source / readout logic (master) and
// the trigger capture buffer (slave).
// Optional macro TRIGCAP_PATTERN_EN adds the trig_pattern/trig_mask signals.
interface trigcap_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic             arm;
    logic             abort;
    logic             trig;
    logic [1:0]       trig_mode;
    logic [AW-1:0]    pre_cnt;
    logic [WIDTH-1:0] din;
    logic             rd_en;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic [WIDTH-1:0] trig_sample;
    logic             crfm;
    logic             busy;
    logic             done;
`ifdef TRIGCAP_PATTERN_EN
    logic [WIDTH-1:0] trig_pattern;
    logic [WIDTH-1:0] trig_mask;

    modport master (
        output arm, abort, trig, trig_mode, pre_cnt, din, rd_en,
               trig_pattern, trig_mask,
        input  dout, dout_valid, trig_sample, crfm, busy, done
    );

    modport slave (
        input  arm, abort, trig, trig_mode, pre_cnt, din, rd_en,
               trig_pattern, trig_mask,
        output dout, dout_valid, trig_sample, crfm, busy, done
    );
`else
    modport master (
        output arm, abort, trig, trig_mode, pre_cnt, din, rd_en,
        input  dout, dout_valid, trig_sample, crfm, busy, done
    );

    modport slave (
        input  arm, abort, trig, trig_mode, pre_cnt, din, rd_en,
        output dout, dout_valid, trig_sample, crfm, busy, done
    );
`endif

endinterface

// File: rtl/trigcap_ram.sv
// WIDTH x DEPTH simple dual-port sample store: synchronous write, registered
// read. The read register holds its value between reads and is the dout bus.
module trigcap_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Sample array: no reset, contents are only meaningful after a capture.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register: cleared by reset, otherwise keeps the last popped sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/trigger_capture_buf.sv
// Circular trigger capture buffer: once armed, records din every cycle,
// keeps pre_cnt samples ahead of the qualified trigger, fills the rest of the
// DEPTH-sample window after it, then offers the window oldest-first.
// Optional macro TRIGCAP_PATTERN_EN adds a masked data-pattern trigger.
module trigger_capture_buf
    import trigcap_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input logic     clk,
    input logic     rst,
    trigcap_if.slave bus
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t state;
    state_t next_state;

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_cnt;
    logic [AW-1:0]    rd_addr;
    logic [AW-1:0]    post_cnt;
    logic [AW-1:0]    pre_q;
    logic             trig_q;
    logic             pat_hit;
    logic             trig_hit;
    logic             we;
    logic             re;
    logic             busy;
    logic             done;
    logic             crfm;
    logic             dout_valid;
    logic [WIDTH-1:0] trig_sample;
    logic [WIDTH-1:0] dout;

`ifdef TRIGCAP_PATTERN_EN
    assign pat_hit = (bus.trig_mask != '0) &&
                     ((bus.din & bus.trig_mask) == (bus.trig_pattern & bus.trig_mask));
`else
    assign pat_hit = 1'b0;
`endif

    assign trig_hit = (state == WAIT) &&
                      (mode_match(bus.trig_mode, bus.trig, trig_q) || pat_hit);

    // Writes are frozen in DONE, so the write pointer is also where the oldest
    // sample of the window lives; reads walk forward from it.
    assign rd_addr = wr_ptr + rd_cnt;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; abort overrides everything else.
    always_comb begin
        next_state = state;
        if (bus.abort) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.arm) begin
                        next_state = (bus.pre_cnt == '0) ? WAIT : FILL;
                    end
                end
                FILL: begin
                    if (wr_ptr == pre_q - AW'(1)) begin
                        next_state = WAIT;
                    end
                end
                WAIT: begin
                    if (trig_hit) begin
                        next_state = (pre_q == LAST) ? DONE : POST;
                    end
                end
                POST: begin
                    if (post_cnt == AW'(1)) begin
                        next_state = DONE;
                    end
                end
                DONE: begin
                    if (bus.rd_en && rd_cnt == LAST) begin
                        next_state = IDLE;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // State-decoded outputs and memory strobes.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        we   = 1'b0;
        re   = 1'b0;
        case (state)
            FILL, WAIT, POST: begin
                busy = 1'b1;
                we   = ~bus.abort;
            end
            DONE: begin
                done = 1'b1;
                re   = bus.rd_en & ~bus.abort;
            end
            default: ;
        endcase
    end

    // Pointers, counters, trigger history and the registered pulse outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_cnt      <= '0;
            post_cnt    <= '0;
            pre_q       <= '0;
            trig_q      <= 1'b0;
            crfm        <= 1'b0;
            dout_valid  <= 1'b0;
            trig_sample <= '0;
        end else begin
            trig_q     <= bus.trig;
            dout_valid <= re;
            crfm       <= trig_hit & ~bus.abort;
            if (trig_hit && !bus.abort) begin
                trig_sample <= bus.din;
            end
            if (bus.abort) begin
                wr_ptr   <= '0;
                rd_cnt   <= '0;
                post_cnt <= '0;
                pre_q    <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.arm) begin
                            pre_q  <= bus.pre_cnt;
                            wr_ptr <= '0;
                            rd_cnt <= '0;
                        end
                    end
                    FILL: begin
                        wr_ptr <= wr_ptr + AW'(1);
                    end
                    WAIT: begin
                        wr_ptr <= wr_ptr + AW'(1);
                        if (trig_hit) begin
                            post_cnt <= LAST - pre_q;
                        end
                    end
                    POST: begin
                        wr_ptr   <= wr_ptr + AW'(1);
                        post_cnt <= post_cnt - AW'(1);
                    end
                    DONE: begin
                        if (bus.rd_en) begin
                            rd_cnt <= rd_cnt + AW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    trigcap_ram #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_ram (
        .clk  (clk),
        .rst  (rst),
        .we   (we),
        .waddr(wr_ptr),
        .wdata(bus.din),
        .re   (re),
        .raddr(rd_addr),
        .rdata(dout)
    );

    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.crfm        = crfm;
    assign bus.dout_valid  = dout_valid;
    assign bus.trig_sample = trig_sample;
    assign bus.dout        = dout;

endmodule

// File: tb/tb_trigger_capture_buf.sv
// Directed bench for trigger_capture_buf (WIDTH=8, DEPTH=16): rising, level
// and falling captures, abort in POST, reset in DONE and, when built with
// TRIGCAP_PATTERN_EN, the masked pattern trigger.
module tb_trigger_capture_buf;
    import trigcap_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests_run = 0;
    int   fail_count = 0;

    trigcap_if #(.WIDTH(8), .DEPTH(16)) bus ();

    trigger_capture_buf #(.WIDTH(8), .DEPTH(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // 10 time-unit clock.
    always #5 clk = ~clk;

    // Hard stop in case a step never comes back.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs,
                                input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Arm with rising mode, feed din from first upward, pulse trig on tval,
    // then run the post-trigger fill and check done timing.
    task automatic run_rise(input int pre, input logic [7:0] first,
                            input logic [7:0] tval);
        logic [7:0] d;
        int npost;
        npost = 15 - pre;
        bus.trig_mode = TM_RISE;
        bus.pre_cnt = 4'(pre);
        bus.trig = 1'b0;
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
        check_output("armed_busy", 32'(bus.busy), 32'd1);
        d = first;
        for (int n = 0; n < 256 && d != tval; n++) begin
            bus.din = d;
            tick();
            d = d + 8'd1;
        end
        bus.din = tval;
        bus.trig = 1'b1;
        tick();
        check_output("trig_crfm", 32'(bus.crfm), 32'd1);
        check_output("trig_sample", 32'(bus.trig_sample), 32'(tval));
        bus.trig = 1'b0;
        for (int i = 1; i <= npost; i++) begin
            bus.din = 8'(tval + 8'(i));
            tick();
            if (i == 1) check_output("crfm_one_shot", 32'(bus.crfm), 32'd0);
            if (i == npost - 1) check_output("done_early", 32'(bus.done), 32'd0);
        end
        check_output("done_on_time", 32'(bus.done), 32'd1);
        check_output("busy_in_done", 32'(bus.busy), 32'd0);
    endtask

    // Pop the whole window: one isolated read first, then fifteen back-to-back.
    task automatic read_window(input logic [7:0] start);
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        check_output("rd0_valid", 32'(bus.dout_valid), 32'd1);
        check_output("rd0_data", 32'(bus.dout), 32'(start));
        tick();
        check_output("rd_gap_valid", 32'(bus.dout_valid), 32'd0);
        check_output("rd_gap_hold", 32'(bus.dout), 32'(start));
        check_output("rd_gap_done", 32'(bus.done), 32'd1);
        bus.rd_en = 1'b1;
        for (int i = 1; i < 16; i++) begin
            tick();
            check_output("rd_valid", 32'(bus.dout_valid), 32'd1);
            check_output("rd_data", 32'(bus.dout), 32'(8'(start + 8'(i))));
            check_output("rd_done", 32'(bus.done), (i < 15) ? 32'd1 : 32'd0);
        end
        bus.rd_en = 1'b0;
        tick();
        check_output("rd_end_valid", 32'(bus.dout_valid), 32'd0);
        check_output("rd_end_busy", 32'(bus.busy), 32'd0);
        check_output("rd_end_done", 32'(bus.done), 32'd0);
    endtask

    initial begin
        logic [7:0] d;
        bus.arm = 1'b0;
        bus.abort = 1'b0;
        bus.trig = 1'b0;
        bus.trig_mode = TM_LEVEL;
        bus.pre_cnt = '0;
        bus.din = '0;
        bus.rd_en = 1'b0;
`ifdef TRIGCAP_PATTERN_EN
        bus.trig_pattern = '0;
        bus.trig_mask = '0;
`endif

        // Reset state.
        repeat (2) tick();
        check_output("rst_busy", 32'(bus.busy), 32'd0);
        check_output("rst_done", 32'(bus.done), 32'd0);
        check_output("rst_dout", 32'(bus.dout), 32'd0);
        check_output("rst_valid", 32'(bus.dout_valid), 32'd0);
        check_output("rst_crfm", 32'(bus.crfm), 32'd0);
        check_output("rst_tsample", 32'(bus.trig_sample), 32'd0);
        rst = 1'b0;
        tick();

        // 1: pre 4, rising trigger at 0x20.
        run_rise(4, 8'h00, 8'h20);
        read_window(8'h1C);

        // 2: pre 8, level trigger already high during FILL.
        bus.trig_mode = TM_LEVEL;
        bus.pre_cnt = 4'd8;
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.din = 8'(i);
            bus.trig = (i >= 1);
            tick();
            check_output("lvl_fill_crfm", 32'(bus.crfm), 32'd0);
        end
        bus.din = 8'h08;
        tick();
        check_output("lvl_crfm", 32'(bus.crfm), 32'd1);
        check_output("lvl_tsample", 32'(bus.trig_sample), 32'h08);
        for (int i = 9; i < 16; i++) begin
            bus.din = 8'(i);
            tick();
            check_output("lvl_post_crfm", 32'(bus.crfm), 32'd0);
        end
        bus.trig = 1'b0;
        check_output("lvl_done", 32'(bus.done), 32'd1);
        read_window(8'h00);

        // 3: pre 0, falling trigger at 0x40.
        bus.trig_mode = TM_FALL;
        bus.pre_cnt = 4'd0;
        bus.trig = 1'b1;
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
        for (int i = 8'h38; i < 8'h40; i++) begin
            bus.din = 8'(i);
            tick();
        end
        check_output("fall_no_early", 32'(bus.crfm), 32'd0);
        bus.din = 8'h40;
        bus.trig = 1'b0;
        tick();
        check_output("fall_crfm", 32'(bus.crfm), 32'd1);
        check_output("fall_tsample", 32'(bus.trig_sample), 32'h40);
        for (int i = 1; i <= 15; i++) begin
            bus.din = 8'(8'h40 + i);
            tick();
            if (i == 14) check_output("fall_done_early", 32'(bus.done), 32'd0);
        end
        check_output("fall_done", 32'(bus.done), 32'd1);
        read_window(8'h40);

        // 4: abort during POST, reads then ignored, fresh capture afterwards.
        bus.trig_mode = TM_RISE;
        bus.pre_cnt = 4'd2;
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.din = 8'(i);
            tick();
        end
        bus.din = 8'h04;
        bus.trig = 1'b1;
        tick();
        check_output("abt_crfm", 32'(bus.crfm), 32'd1);
        bus.trig = 1'b0;
        for (int i = 5; i < 7; i++) begin
            bus.din = 8'(i);
            tick();
        end
        check_output("abt_busy_post", 32'(bus.busy), 32'd1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check_output("abt_busy", 32'(bus.busy), 32'd0);
        check_output("abt_done", 32'(bus.done), 32'd0);
        check_output("abt_crfm_off", 32'(bus.crfm), 32'd0);
        bus.rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.din = 8'(i + 7);
            tick();
            check_output("abt_no_done", 32'(bus.done), 32'd0);
            check_output("abt_no_valid", 32'(bus.dout_valid), 32'd0);
        end
        bus.rd_en = 1'b0;
        check_output("abt_dout_hold", 32'(bus.dout), 32'h4F);
        run_rise(4, 8'h50, 8'h60);
        read_window(8'h5C);

        // 5: asynchronous reset in the middle of DONE.
        run_rise(4, 8'h60, 8'h70);
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        check_output("pre_rst_dout", 32'(bus.dout), 32'h6C);
        #2;
        rst = 1'b1;
        #1;
        check_output("mid_rst_done", 32'(bus.done), 32'd0);
        check_output("mid_rst_busy", 32'(bus.busy), 32'd0);
        check_output("mid_rst_dout", 32'(bus.dout), 32'd0);
        check_output("mid_rst_valid", 32'(bus.dout_valid), 32'd0);
        check_output("mid_rst_tsample", 32'(bus.trig_sample), 32'd0);
        check_output("mid_rst_crfm", 32'(bus.crfm), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_output("post_rst_idle", 32'(bus.busy), 32'd0);
        run_rise(3, 8'h00, 8'h08);
        read_window(8'h05);

`ifdef TRIGCAP_PATTERN_EN
        // 6: masked pattern trigger with trig held low, then mask 0.
        bus.trig = 1'b0;
        bus.trig_mode = TM_RISE;
        bus.trig_mask = 8'hF0;
        bus.trig_pattern = 8'h30;
        bus.pre_cnt = 4'd4;
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
        for (int i = 8'h20; i < 8'h30; i++) begin
            bus.din = 8'(i);
            tick();
        end
        check_output("pat_no_early", 32'(bus.crfm), 32'd0);
        bus.din = 8'h30;
        tick();
        check_output("pat_crfm", 32'(bus.crfm), 32'd1);
        check_output("pat_tsample", 32'(bus.trig_sample), 32'h30);
        for (int i = 8'h31; i <= 8'h3B; i++) begin
            bus.din = 8'(i);
            tick();
        end
        check_output("pat_done", 32'(bus.done), 32'd1);
        read_window(8'h2C);
        bus.trig_mask = 8'h00;
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
        d = 8'h28;
        for (int i = 0; i < 24; i++) begin
            bus.din = d;
            tick();
            check_output("mask0_no_crfm", 32'(bus.crfm), 32'd0);
            d = d + 8'd1;
        end
        check_output("mask0_busy", 32'(bus.busy), 32'd1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check_output("mask0_abort", 32'(bus.busy), 32'd0);
`else
        d = 8'h00;
        bus.din = d;
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
